// File: rtl/div_param_seq_if.sv
// Start/busy/valid handshake bundle for div_param_seq.
// master: the requester driving operands; slave: the divider.
interface div_param_seq_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             valid;
    logic             ov;
    logic             dvz;

    modport master (
        output start, A, B,
        input  Q, R, busy, valid, ov, dvz
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, valid, ov, dvz
    );
endinterface

// File: rtl/div_param_seq.sv
// div_param_seq: sequential restoring fixed-point divider.
//   Q = floor(A * 2^FRAC / B), R = (A * 2^FRAC) mod B, one quotient bit per clock.
//   The interface instance must use the same WIDTH as this module.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands, extra SIGN state).
module div_param_seq #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 5
) (
    input  logic             clk,
    input  logic             rst,
    div_param_seq_if.slave   bus
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;

    // Working registers (not reset: only meaningful between start and DONE)
    logic [N-1:0]     dvd;
    logic [N-1:0]     quo;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] a_raw;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             take;

`ifdef DIV_SIGNED_EN
    localparam logic [N-1:0] HALF = N'(1) << (WIDTH - 1);

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             res_ov;

    // WIDTH+1-bit magnitude so that -2^(WIDTH-1) is representable
    function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] ext;
        ext = v;
        return ext[WIDTH] ? -ext : ext;
    endfunction

    // Signed range check on the full N-bit quotient magnitude
    function automatic logic signed_ov(input logic [N-1:0] qm, input logic neg);
        return neg ? (qm > HALF) : (qm >= HALF);
    endfunction
`else
    // Unsigned overflow: any bit above the WIDTH-bit result is set
    function automatic logic unsigned_ov(input logic [N-1:0] qm);
        return (qm >> WIDTH) != '0;
    endfunction
`endif

    // One restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        trial = {WIDTH'(rem), dvd[N-1]};
        diff  = trial - {1'b0, b_lat};
        take  = (trial >= {1'b0, b_lat});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.B != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                    state_nx = SIGN;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            SIGN:    state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Iteration counter, handshake flags and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
            bus.Q     <= '0;
            bus.R     <= '0;
            bus.ov    <= 1'b0;
            bus.dvz   <= 1'b0;
        end else begin
            bus.busy  <= (state_nx != IDLE);
            bus.valid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt <= (bus.B != '0) ? CW'(N) : '0;
                    end
                end
                RUN: cnt <= cnt - CW'(1);
                DONE: begin
                    if (b_lat == '0) begin
                        bus.Q   <= '1;
                        bus.R   <= a_raw;
                        bus.ov  <= 1'b0;
                        bus.dvz <= 1'b1;
                    end else begin
`ifdef DIV_SIGNED_EN
                        bus.Q   <= res_q;
                        bus.R   <= res_r;
                        bus.ov  <= res_ov;
`else
                        bus.Q   <= WIDTH'(quo);
                        bus.R   <= WIDTH'(rem);
                        bus.ov  <= unsigned_ov(quo);
`endif
                        bus.dvz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand latch, restoring iterations and sign fix-up
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_raw <= bus.A;
`ifdef DIV_SIGNED_EN
                    sa    <= bus.A[WIDTH-1];
                    sb    <= bus.B[WIDTH-1];
                    dvd   <= N'(mag(bus.A)) << FRAC;
                    b_lat <= WIDTH'(mag(bus.B));
`else
                    dvd   <= N'(bus.A) << FRAC;
                    b_lat <= bus.B;
`endif
                    rem   <= '0;
                    quo   <= '0;
                end
            end
            RUN: begin
                rem <= take ? diff : trial;
                quo <= {quo[N-2:0], take};
                dvd <= dvd << 1;
            end
`ifdef DIV_SIGNED_EN
            SIGN: begin
                res_q  <= (sa ^ sb) ? WIDTH'(-quo) : WIDTH'(quo);
                res_r  <= sa ? WIDTH'(-rem) : WIDTH'(rem);
                res_ov <= signed_ov(quo, sa ^ sb);
            end
`endif
            default: ;
        endcase
    end

endmodule
